// File: rtl/sword_anim_sequencer.sv
// -----------------------------------------------------------------------------
// sword_anim_sequencer
//
// Address/frame generator for the sword-swing sprite ROMs (sword_down_1..3).
// An attack request starts a three-frame swing. Each frame is held for
// HOLD_FRAMES vertical-sync ticks. Every pixel clock the current DrawX/DrawY
// and the sprite's top-left position are turned into a registered texel
// address, a frame select and an on-sprite flag for the ROM/palette stage.
// The address path has one cycle of latency; the downstream ROM adds one more,
// and the consumer delays blank by two cycles to match.
//
// Parameters:
//   SPRITE_W     sprite width/height in ROM texels (square, power of two)
//   HOLD_FRAMES  vsync ticks each animation frame is held (>= 1)
//
// Optional feature (compile-time macro SWORD_SCALE2X_EN):
//   defined   - sprite is drawn 2x: on-screen box is 2*SPRITE_W square and
//               each texel covers a 2x2 pixel block.
//   undefined - 1:1 texel-to-pixel mapping.
//
// Ports:
//   vga_clk      in   pixel clock
//   reset_n      in   asynchronous active-low reset
//   vs           in   VGA vertical sync, active low
//   DrawX/DrawY  in   current pixel column/row (10 bits)
//   sprite_x/y   in   sprite top-left column/row (10 bits)
//   attack       in   level request to start a swing (sampled in IDLE only)
//   rom_address  out  texel address rel_y*SPRITE_W+rel_x, 0 outside the box
//   frame_sel    out  0 = none, 1..3 = sword_down_N ROM to read
//   sprite_on    out  current pixel lies inside the active sprite
//   busy         out  swing in progress
//   done         out  one-cycle pulse when the swing completes
// -----------------------------------------------------------------------------
module sword_anim_sequencer #(
  parameter int unsigned SPRITE_W    = 32,
  parameter int unsigned HOLD_FRAMES = 4
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       vs,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic [9:0] sprite_x,
  input  logic [9:0] sprite_y,
  input  logic       attack,
  output logic [9:0] rom_address,
  output logic [1:0] frame_sel,
  output logic       sprite_on,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam int unsigned PW = 11;

`ifdef SWORD_SCALE2X_EN
  localparam int unsigned BOX_W = 2 * SPRITE_W;
`else
  localparam int unsigned BOX_W = SPRITE_W;
`endif

  // State encoding doubles as the frame_sel value for F1..F3.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_F1   = 2'd1;
  localparam logic [1:0] S_F2   = 2'd2;
  localparam logic [1:0] S_F3   = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] hold_cnt, hold_cnt_nxt;
  logic          vs_prev;
  logic          frame_tick;
  logic          done_nxt;
  logic [1:0]    frame_sel_nxt;
  logic          busy_nxt;

  logic [PW-1:0] draw_x_w, draw_y_w, spr_x_w, spr_y_w;
  logic [PW-1:0] rel_x, rel_y, tex_x, tex_y, addr_w;
  logic          in_box;

  // One tick per frame: falling edge of vs against its registered copy.
  assign frame_tick = vs_prev & ~vs;

  // State, hold counter and vsync history.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      hold_cnt <= '0;
      vs_prev  <= 1'b1;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      vs_prev  <= vs;
    end
  end

  // Next-state, hold counter and registered-output next values.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    done_nxt     = 1'b0;
    case (state)
      S_IDLE: begin
        // A tick in the same cycle as attack is absorbed: F1 starts at 0.
        hold_cnt_nxt = '0;
        if (attack) begin
          state_nxt = S_F1;
        end
      end
      default: begin
        if (frame_tick) begin
          if (hold_cnt == CW'(HOLD_FRAMES - 1)) begin
            hold_cnt_nxt = '0;
            if (state == S_F3) begin
              state_nxt = S_IDLE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = state + 2'd1;
            end
          end else begin
            hold_cnt_nxt = hold_cnt + CW'(1);
          end
        end
      end
    endcase
    frame_sel_nxt = state_nxt;
    busy_nxt      = (state_nxt != S_IDLE);
  end

  // Sprite-relative coordinates in 11 bits so boxes near column 1023 do not wrap.
  always_comb begin
    draw_x_w = PW'(DrawX);
    draw_y_w = PW'(DrawY);
    spr_x_w  = PW'(sprite_x);
    spr_y_w  = PW'(sprite_y);
    rel_x    = draw_x_w - spr_x_w;
    rel_y    = draw_y_w - spr_y_w;
    in_box   = (draw_x_w >= spr_x_w) && (draw_x_w < spr_x_w + PW'(BOX_W)) &&
               (draw_y_w >= spr_y_w) && (draw_y_w < spr_y_w + PW'(BOX_W));
`ifdef SWORD_SCALE2X_EN
    tex_x    = rel_x >> 1;
    tex_y    = rel_y >> 1;
`else
    tex_x    = rel_x;
    tex_y    = rel_y;
`endif
    // Only meaningful inside the box, where the result fits in 10 bits.
    addr_w   = tex_y * PW'(SPRITE_W) + tex_x;
  end

  // Registered outputs; sprite_on uses the state of the sampling cycle.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_sel   <= 2'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sprite_on   <= 1'b0;
      rom_address <= 10'd0;
    end else begin
      frame_sel   <= frame_sel_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      sprite_on   <= in_box && (state != S_IDLE);
      rom_address <= in_box ? 10'(addr_w) : 10'd0;
    end
  end

endmodule

// File: tb/tb_sword_anim_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sword_anim_sequencer
//
// Scoreboard bench: the driver applies inputs on the falling clock edge and
// pushes the response a behavioural model predicts for the next rising edge;
// a monitor pops and compares one entry per cycle shortly after that edge.
// -----------------------------------------------------------------------------
module tb_sword_anim_sequencer;

  localparam int HOLD = 2;
  localparam int SW   = 32;
`ifdef SWORD_SCALE2X_EN
  localparam int SCALE = 2;
`else
  localparam int SCALE = 1;
`endif

  logic       vga_clk;
  logic       reset_n;
  logic       vs;
  logic [9:0] DrawX, DrawY, sprite_x, sprite_y;
  logic       attack;
  logic [9:0] rom_address;
  logic [1:0] frame_sel;
  logic       sprite_on, busy, done;

  typedef struct packed {
    logic [1:0] fs;
    logic       busy;
    logic       done;
    logic       on;
    logic [9:0] addr;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  // Stimulus values held between driven cycles.
  logic cur_vs = 1'b1;
  int   cur_dx = 0, cur_dy = 0, cur_sx = 0, cur_sy = 0;

  // Reference model: which frame of the swing we are in and ticks seen in it.
  int   m_frame = 0;
  int   m_ticks = 0;
  logic m_vsp   = 1'b1;

  sword_anim_sequencer #(.SPRITE_W(SW), .HOLD_FRAMES(HOLD)) dut (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .vs         (vs),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .sprite_x   (sprite_x),
    .sprite_y   (sprite_y),
    .attack     (attack),
    .rom_address(rom_address),
    .frame_sel  (frame_sel),
    .sprite_on  (sprite_on),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    vga_clk = 1'b0;
    forever #5 vga_clk = ~vga_clk;
  end

  task automatic model_step(input logic r, input logic v, input logic a,
                            input int dx, input int dy, input int sx, input int sy,
                            output exp_t e);
    int   w;
    int   addr;
    logic inb;
    logic tick;
    e = '0;
    if (!r) begin
      m_frame = 0;
      m_ticks = 0;
      m_vsp   = 1'b1;
    end else begin
      w    = SW * SCALE;
      inb  = (dx >= sx) && (dx < sx + w) && (dy >= sy) && (dy < sy + w);
      addr = inb ? ((dy - sy) / SCALE) * SW + (dx - sx) / SCALE : 0;
      e.on   = inb && (m_frame != 0);
      e.addr = 10'(addr);
      tick   = m_vsp && !v;
      if (m_frame == 0) begin
        if (a) begin
          m_frame = 1;
          m_ticks = 0;
        end
      end else if (tick) begin
        m_ticks++;
        if (m_ticks == HOLD) begin
          m_ticks = 0;
          if (m_frame == 3) begin
            m_frame = 0;
            e.done  = 1'b1;
          end else begin
            m_frame++;
          end
        end
      end
      m_vsp  = v;
      e.fs   = 2'(m_frame);
      e.busy = (m_frame != 0);
    end
  endtask

  // Apply one cycle of inputs and queue the predicted response.
  task automatic drive(input logic r, input logic a);
    exp_t e;
    @(negedge vga_clk);
    reset_n  = r;
    vs       = cur_vs;
    attack   = a;
    DrawX    = 10'(cur_dx);
    DrawY    = 10'(cur_dy);
    sprite_x = 10'(cur_sx);
    sprite_y = 10'(cur_sy);
    model_step(r, cur_vs, a, cur_dx, cur_dy, cur_sx, cur_sy, e);
    q.push_back(e);
    if (!r) begin
      #1;
      checks++;
      if ({frame_sel, busy, done, sprite_on, rom_address} !== 15'd0) begin
        fails++;
        $display("FAIL reset_async: got fs=%0d busy=%0b done=%0b on=%0b addr=%0d, want all 0",
                 frame_sel, busy, done, sprite_on, rom_address);
      end else begin
        passes++;
      end
    end
  endtask

  // n vsync periods, each contributing one falling edge.
  task automatic ticks(input int n, input logic a);
    for (int i = 0; i < n; i++) begin
      cur_vs = 1'b1; drive(1'b1, a); drive(1'b1, a);
      cur_vs = 1'b0; drive(1'b1, a); drive(1'b1, a);
    end
  endtask

  // Monitor: one queued expectation per rising edge.
  always @(posedge vga_clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (frame_sel !== e.fs || busy !== e.busy || done !== e.done ||
          sprite_on !== e.on || rom_address !== e.addr) begin
        fails++;
        $display("FAIL cycle_out @%0t: got fs=%0d busy=%0b done=%0b on=%0b addr=%0d, want fs=%0d busy=%0b done=%0b on=%0b addr=%0d",
                 $time, frame_sel, busy, done, sprite_on, rom_address,
                 e.fs, e.busy, e.done, e.on, e.addr);
      end else begin
        passes++;
      end
    end
  end

  initial begin
    int t;
    reset_n  = 1'b0;
    vs       = 1'b1;
    attack   = 1'b1;
    cur_sx = 100; cur_sy = 50; cur_dx = 105; cur_dy = 53;
    DrawX    = 10'(cur_dx);
    DrawY    = 10'(cur_dy);
    sprite_x = 10'(cur_sx);
    sprite_y = 10'(cur_sy);
    #2;
    checks++;
    if ({frame_sel, busy, done, sprite_on, rom_address} !== 15'd0) begin
      fails++;
      $display("FAIL reset_init: got fs=%0d busy=%0b done=%0b on=%0b addr=%0d, want all 0",
               frame_sel, busy, done, sprite_on, rom_address);
    end else begin
      passes++;
    end

    // Reset held with attack high, then release: F1 one edge later.
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);

    // Full swing; mid-way move DrawX just past the box edge.
    ticks(2, 1'b0);
    cur_dx = 132;
    ticks(2, 1'b0);
    cur_dx = 105;
    ticks(2, 1'b0);
    drive(1'b1, 1'b0);

    // Second swing with attack re-asserted during F2 (must be ignored).
    drive(1'b1, 1'b1);
    ticks(2, 1'b0);
    ticks(2, 1'b1);
    ticks(2, 1'b0);
    drive(1'b1, 1'b0);

    // Right-edge positions while busy: no wrap, and an in-box pixel near 639.
    drive(1'b1, 1'b1);
    cur_sx = 1000; cur_dx = 5;
    drive(1'b1, 1'b0); drive(1'b1, 1'b0);
    cur_sx = 620; cur_dx = 639;
    drive(1'b1, 1'b0); drive(1'b1, 1'b0);
    cur_sx = 1000; cur_dx = 1023; cur_sy = 1000; cur_dy = 1023;
    drive(1'b1, 1'b0); drive(1'b1, 1'b0);

    // Reset in F2 mid-swing: immediate IDLE, no done pulse.
    cur_sx = 100; cur_sy = 50; cur_dx = 105; cur_dy = 53;
    ticks(2, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);

    // Tick coincident with attack in IDLE: counter must start at 0.
    cur_vs = 1'b1; drive(1'b1, 1'b0);
    cur_vs = 1'b0; drive(1'b1, 1'b1);
    ticks(6, 1'b0);

    // Origin sprite: bottom-right texel and first pixel beyond the box.
    cur_sx = 0; cur_sy = 0; cur_dx = 63; cur_dy = 63;
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    cur_dx = 64;
    drive(1'b1, 1'b0);
    cur_dx = 31; cur_dy = 31;
    drive(1'b1, 1'b0);
    cur_dx = 32;
    drive(1'b1, 1'b0);

    // Randomized traffic with pixels clustered around the sprite.
    for (int i = 0; i < 4000; i++) begin
      logic r;
      logic a;
      if ($urandom_range(0, 5) == 0) cur_vs = ~cur_vs;
      if ($urandom_range(0, 199) == 0) begin
        cur_sx = int'($urandom_range(0, 1023));
        cur_sy = int'($urandom_range(0, 1023));
      end
      if ($urandom_range(0, 3) == 0) begin
        cur_dx = int'($urandom_range(0, 1023));
        cur_dy = int'($urandom_range(0, 1023));
      end else begin
        t = cur_sx + int'($urandom_range(0, 80)) - 8;
        cur_dx = (t < 0) ? 0 : ((t > 1023) ? 1023 : t);
        t = cur_sy + int'($urandom_range(0, 80)) - 8;
        cur_dy = (t < 0) ? 0 : ((t > 1023) ? 1023 : t);
      end
      a = ($urandom_range(0, 15) == 0);
      r = ($urandom_range(0, 399) != 0);
      drive(r, a);
    end

    // Drain the scoreboard.
    repeat (3) @(posedge vga_clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end else begin
      passes++;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
